gpo_bank_ctrl: RTL and testbench

GPO_BANK_CTRL -- requirements
Module: gpo_bank_ctrl

---
 rtl/gpo_bank_pkg.sv | 25 ++
 rtl/gpo_bank_ch.sv | 103 ++++++++++
 rtl/gpo_bank_ctrl.sv | 93 +++++++++
 tb/tb_gpo_bank_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpo_bank_pkg.sv
// gpo_bank_pkg: shared types and helpers for the GPO pad bank.
// Channel state, pad mode encoding and settle counter sizing.
package gpo_bank_pkg;

  localparam int GPO_DS_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ON    = 2'd1,
    BREAK = 2'd2
  } ch_state_t;

  typedef enum logic [1:0] {
    MODE_PP  = 2'b00,
    MODE_OD  = 2'b01,
    MODE_OS  = 2'b10,
    MODE_RSV = 2'b11
  } gpo_mode_t;

  // counter only has to reach settle-1
  function automatic int cnt_w(input int settle);
    return (settle <= 1) ? 1 : $clog2(settle);
  endfunction

endpackage

// File: rtl/gpo_bank_ch.sv
// gpo_bank_ch: one pad channel with break-before-make sequencing.
// Any drive/mode change while enabled tristates the pad for SETTLE_CYC.
module gpo_bank_ch
  import gpo_bank_pkg::*;
#(
  parameter int SETTLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dout,
  input  logic                oe_req,
  input  logic [GPO_DS_W-1:0] ds_req,
  input  logic [1:0]          mode,
  input  logic                vbias_ok,
  output logic                pad_do,
  output logic                pad_oe,
  output logic                pad_odp,
  output logic                pad_odn,
  output logic [GPO_DS_W-1:0] pad_ds,
  output logic                busy
);

  localparam int CW = cnt_w(SETTLE_CYC);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYC - 1);

  ch_state_t           state;
  gpo_mode_t           mode_q;
  gpo_mode_t           mode_in;
  logic [CW-1:0]       cnt;
  logic [GPO_DS_W-1:0] eff_ds;
  logic                changed;
  logic                reserved;

  assign mode_in  = gpo_mode_t'(mode);
  assign eff_ds   = vbias_ok ? ds_req : '0;
  assign reserved = (mode_in == MODE_RSV);
  // pad_ds/mode_q always hold what the pad currently sees
  assign changed  = (eff_ds != pad_ds) || (mode_in != mode_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= MODE_PP;
      cnt     <= '0;
      pad_do  <= 1'b0;
      pad_oe  <= 1'b0;
      pad_odp <= 1'b0;
      pad_odn <= 1'b0;
      pad_ds  <= '0;
      busy    <= 1'b0;
    end else begin
      pad_do  <= dout;
      pad_ds  <= eff_ds;
      mode_q  <= mode_in;
      pad_odp <= (mode_in == MODE_OD);
      pad_odn <= (mode_in == MODE_OS);
      unique case (state)
        IDLE: begin
          cnt  <= '0;
          busy <= 1'b0;
          if (oe_req && !reserved) begin
            state  <= ON;
            pad_oe <= 1'b1;
          end else begin
            pad_oe <= 1'b0;
          end
        end
        ON, BREAK: begin
          if (!oe_req || reserved) begin
            state  <= IDLE;
            pad_oe <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
          end else if (changed) begin
            state  <= BREAK;
            pad_oe <= 1'b0;
            busy   <= 1'b1;
            cnt    <= '0;
          end else if (state == ON) begin
            pad_oe <= 1'b1;
            busy   <= 1'b0;
          end else if (cnt == LAST) begin
            state  <= ON;
            pad_oe <= 1'b1;
            busy   <= 1'b0;
            cnt    <= '0;
          end else begin
            pad_oe <= 1'b0;
            busy   <= 1'b1;
            cnt    <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          pad_oe <= 1'b0;
          busy   <= 1'b0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/gpo_bank_ctrl.sv
// gpo_bank_ctrl: bank of NCH GPO pad channels plus bank-wide SR/CO.
// Define GPO_BANK_BIASFLT_EN to add the sticky bias-fault flag.
module gpo_bank_ctrl
  import gpo_bank_pkg::*;
#(
  parameter int NCH        = 8,
  parameter int SETTLE_CYC = 4
) (
  input  logic                    CLK_I,
  input  logic                    RSTN_I,
  input  logic [NCH-1:0]          DO_I,
  input  logic [NCH-1:0]          OE_I,
  input  logic [GPO_DS_W*NCH-1:0] DS_REQ_I,
  input  logic [2*NCH-1:0]        MODE_I,
  input  logic                    SR_I,
  input  logic                    CO_I,
  input  logic                    VBIAS_OK_I,
`ifdef GPO_BANK_BIASFLT_EN
  input  logic                    FLT_CLR_I,
  output logic                    BIAS_FLT_O,
`endif
  output logic [NCH-1:0]          PAD_DO_O,
  output logic [NCH-1:0]          PAD_OE_O,
  output logic [NCH-1:0]          PAD_ODP_O,
  output logic [NCH-1:0]          PAD_ODN_O,
  output logic [GPO_DS_W*NCH-1:0] PAD_DS_O,
  output logic                    PAD_SR_O,
  output logic                    PAD_CO_O,
  output logic [NCH-1:0]          BUSY_O
);

  if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("gpo_bank_ctrl: SETTLE_CYC must be 1..255");
  end
  if (NCH < 1 || NCH > 32) begin : g_bad_nch
    $error("gpo_bank_ctrl: NCH must be 1..32");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gpo_bank_ch #(
      .SETTLE_CYC(SETTLE_CYC)
    ) u_ch (
      .clk     (CLK_I),
      .rst_n   (RSTN_I),
      .dout    (DO_I[i]),
      .oe_req  (OE_I[i]),
      .ds_req  (DS_REQ_I[GPO_DS_W*i +: GPO_DS_W]),
      .mode    (MODE_I[2*i +: 2]),
      .vbias_ok(VBIAS_OK_I),
      .pad_do  (PAD_DO_O[i]),
      .pad_oe  (PAD_OE_O[i]),
      .pad_odp (PAD_ODP_O[i]),
      .pad_odn (PAD_ODN_O[i]),
      .pad_ds  (PAD_DS_O[GPO_DS_W*i +: GPO_DS_W]),
      .busy    (BUSY_O[i])
    );
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      PAD_SR_O <= 1'b0;
      PAD_CO_O <= 1'b0;
    end else begin
      PAD_SR_O <= SR_I;
      PAD_CO_O <= CO_I;
    end
  end

`ifdef GPO_BANK_BIASFLT_EN
  logic flt_set;

  // a channel is out of IDLE exactly when it is driving or breaking
  always_comb begin
    flt_set = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if ((PAD_OE_O[i] || BUSY_O[i]) &&
          (DS_REQ_I[GPO_DS_W*i +: GPO_DS_W] != '0))
        flt_set = 1'b1;
    end
    flt_set = flt_set && !VBIAS_OK_I;
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I)
      BIAS_FLT_O <= 1'b0;
    else if (flt_set)
      BIAS_FLT_O <= 1'b1;
    else if (FLT_CLR_I)
      BIAS_FLT_O <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_gpo_bank_ctrl.sv
// tb_gpo_bank_ctrl: directed vectors for gpo_bank_ctrl (NCH=8, SETTLE_CYC=4).
// Flag checks are included when GPO_BANK_BIASFLT_EN is defined.
module tb_gpo_bank_ctrl;

  localparam int NCH = 8;

  logic             clk;
  logic             rst_n;
  logic [NCH-1:0]   dout;
  logic [NCH-1:0]   oe;
  logic [2*NCH-1:0] ds;
  logic [2*NCH-1:0] mode;
  logic             sr;
  logic             co;
  logic             vb;
  logic [NCH-1:0]   pad_do;
  logic [NCH-1:0]   pad_oe;
  logic [NCH-1:0]   pad_odp;
  logic [NCH-1:0]   pad_odn;
  logic [2*NCH-1:0] pad_ds;
  logic             pad_sr;
  logic             pad_co;
  logic [NCH-1:0]   busy;
`ifdef GPO_BANK_BIASFLT_EN
  logic             flt_clr;
  logic             flt;
`endif

  int n_vec = 0;
  int n_bad = 0;

  gpo_bank_ctrl #(
    .NCH(NCH),
    .SETTLE_CYC(4)
  ) dut (
    .CLK_I     (clk),
    .RSTN_I    (rst_n),
    .DO_I      (dout),
    .OE_I      (oe),
    .DS_REQ_I  (ds),
    .MODE_I    (mode),
    .SR_I      (sr),
    .CO_I      (co),
    .VBIAS_OK_I(vb),
`ifdef GPO_BANK_BIASFLT_EN
    .FLT_CLR_I (flt_clr),
    .BIAS_FLT_O(flt),
`endif
    .PAD_DO_O  (pad_do),
    .PAD_OE_O  (pad_oe),
    .PAD_ODP_O (pad_odp),
    .PAD_ODN_O (pad_odn),
    .PAD_DS_O  (pad_ds),
    .PAD_SR_O  (pad_sr),
    .PAD_CO_O  (pad_co),
    .BUSY_O    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    oe    = '1;
    ds    = '1;
    dout  = '1;
    mode  = {NCH{2'b01}};
    sr    = 1'b1;
    co    = 1'b1;
    vb    = 1'b1;
`ifdef GPO_BANK_BIASFLT_EN
    flt_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_oe", 32'(pad_oe), 32'h0);
    chk("rst_ds", 32'(pad_ds), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_do", 32'(pad_do), 32'h0);
    chk("rst_odp", 32'(pad_odp), 32'h0);
    chk("rst_sr", 32'(pad_sr), 32'h0);
    chk("rst_co", 32'(pad_co), 32'h0);
`ifdef GPO_BANK_BIASFLT_EN
    chk("rst_flt", 32'(flt), 32'h0);
`endif
    oe    = '0;
    ds    = '0;
    dout  = '0;
    mode  = '0;
    sr    = 1'b0;
    co    = 1'b0;
    rst_n = 1'b1;
    step();
    chk("idle_oe", 32'(pad_oe), 32'h0);

    // IDLE -> ON
    oe[0] = 1'b1;
    ds[1:0] = 2'b01;
    step();
    chk("on_oe", 32'(pad_oe), 32'h01);
    chk("on_ds", 32'(pad_ds[1:0]), 32'h1);
    chk("on_busy", 32'(busy), 32'h0);

    // DS change -> 4 cycles of break
    ds[1:0] = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("brk_oe", 32'(pad_oe[0]), 32'h0);
      chk("brk_busy", 32'(busy), 32'h01);
      chk("brk_ds", 32'(pad_ds[1:0]), 32'h3);
    end
    step();
    chk("brk_end_oe", 32'(pad_oe), 32'h01);
    chk("brk_end_busy", 32'(busy), 32'h0);

    // restart at count 2
    ds[1:0] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_cnt_a", 32'(pad_oe[0]), 32'h0);
    end
    ds[1:0] = 2'b10;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rst_cnt_oe", 32'(pad_oe[0]), 32'h0);
      chk("rst_cnt_ds", 32'(pad_ds[1:0]), 32'h2);
    end
    step();
    chk("rst_cnt_end", 32'(pad_oe[0]), 32'h1);

    // OE fall wins over DS change in BREAK
    ds[1:0] = 2'b11;
    step();
    chk("abort_pre", 32'(busy), 32'h01);
    oe[0] = 1'b0;
    ds[1:0] = 2'b01;
    step();
    chk("abort_oe", 32'(pad_oe), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ds", 32'(pad_ds[1:0]), 32'h1);
    step();
    chk("abort_hold", 32'(busy), 32'h0);

    // bias loss while ON
    oe[0] = 1'b1;
    ds[1:0] = 2'b11;
    step();
    chk("vb_on", 32'(pad_oe[0]), 32'h1);
    vb = 1'b0;
    step();
    chk("vb_oe", 32'(pad_oe[0]), 32'h0);
    chk("vb_ds", 32'(pad_ds[1:0]), 32'h0);
    chk("vb_busy", 32'(busy), 32'h01);
`ifdef GPO_BANK_BIASFLT_EN
    chk("vb_flt", 32'(flt), 32'h1);
    flt_clr = 1'b1;
    step();
    chk("flt_setwins", 32'(flt), 32'h1);
    flt_clr = 1'b0;
`endif
    vb = 1'b1;
    oe[0] = 1'b0;
    step();
    chk("vb_idle", 32'(pad_oe[0]), 32'h0);
    chk("vb_idle_ds", 32'(pad_ds[1:0]), 32'h3);
`ifdef GPO_BANK_BIASFLT_EN
    chk("flt_sticky", 32'(flt), 32'h1);
    flt_clr = 1'b1;
    step();
    chk("flt_clr", 32'(flt), 32'h0);
    flt_clr = 1'b0;
`endif

    // modes
    ds[1:0]   = 2'b00;
    oe[1]     = 1'b1;
    mode[3:2] = 2'b11;
    ds[3:2]   = 2'b01;
    oe[2]     = 1'b1;
    mode[5:4] = 2'b01;
    dout[2]   = 1'b0;
    oe[3]     = 1'b1;
    mode[7:6] = 2'b10;
    dout[3]   = 1'b1;
    sr = 1'b1;
    co = 1'b0;
    step();
    chk("mode_oe", 32'(pad_oe), 32'h0C);
    chk("mode_odp", 32'(pad_odp), 32'h04);
    chk("mode_odn", 32'(pad_odn), 32'h08);
    chk("mode_do", 32'(pad_do), 32'h08);
    chk("mode_ds1", 32'(pad_ds[3:2]), 32'h1);
    chk("sr", 32'(pad_sr), 32'h1);
    chk("co", 32'(pad_co), 32'h0);
    step();
    chk("rsv_hold", 32'(pad_oe), 32'h0C);

    // mode change while ON, other channels unaffected
    mode[5:4] = 2'b00;
    step();
    chk("mchg_oe", 32'(pad_oe), 32'h08);
    chk("mchg_busy", 32'(busy), 32'h04);
    chk("mchg_odp", 32'(pad_odp), 32'h0);

    // reset mid-break, then fresh request
    step();
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", 32'(busy), 32'h0);
    chk("rmid_oe", 32'(pad_oe), 32'h0);
    chk("rmid_ds", 32'(pad_ds), 32'h0);
    rst_n = 1'b1;
    step();
    chk("rel_oe", 32'(pad_oe), 32'h0C);
    chk("rel_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
